slt_sort_engine: RTL



---
 rtl/slt_sort_pkg.sv | 22 ++
 rtl/slt.sv | 23 ++
 rtl/slt_sort_engine.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/slt_sort_pkg.sv
// ============================================================================
// Module      : slt_sort_pkg
// Description : Shared types and constants for the slt_sort_engine block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package slt_sort_pkg;

  // Top-level sequencing states of the sort engine.
  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width of the saturating swap counter.
  localparam int SWAP_W = 16;

endpackage : slt_sort_pkg

`default_nettype wire

// File: rtl/slt.sv
// ============================================================================
// Module      : slt
// Description : Signed strict less-than comparator, out_o = (a_i < b_i).
//               Two's-complement ordering, so the most-negative value
//               compares below the most-positive one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         out_o
);

  // Signed compare; no wrap-around subtract, so no overflow can flip it.
  assign out_o = ($signed(a_i) < $signed(b_i));

endmodule : slt

`default_nettype wire

// File: rtl/slt_sort_engine.sv
// ============================================================================
// Module      : slt_sort_engine
// Description : Sequential bubble sorter (early exit) over M signed N-bit
//               entries. One shared slt comparator, one compare per cycle.
//               Values stream in over valid/ready, sorting begins on start,
//               results are read back combinationally by address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module slt_sort_engine
  import slt_sort_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic                   start,
  input  logic                   clear,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(M):0]     count,
  output logic [SWAP_W-1:0]      swaps,
  input  logic [$clog2(M)-1:0]   rd_addr,
  output logic [N-1:0]           rd_data
);

  localparam int c_ADDR_W = $clog2(M);
  localparam int c_CNT_W  = c_ADDR_W + 1;

  // Architectural state
  logic [N-1:0]          mem_q [M];
  state_e                state_q;
  logic [c_CNT_W-1:0]    count_q;
  logic [SWAP_W-1:0]     swaps_q;
  logic [c_ADDR_W-1:0]   j_q;          // lower index of the pair being compared
  logic [c_ADDR_W-1:0]   lim_q;        // compares in the current pass
  logic                  pass_swap_q;  // a swap happened earlier in this pass
  logic                  done_q;

  // Combinational helpers
  logic                  w_load;
  logic [c_CNT_W-1:0]    count_d;
  logic [c_ADDR_W-1:0]   w_lim_init;
  logic [c_ADDR_W-1:0]   w_j1;
  logic [N-1:0]          w_a;
  logic [N-1:0]          w_b;
  logic                  w_lt;
  logic                  w_end_pass;
  logic                  w_pass_any;

  assign w_load  = (state_q == S_LOAD) && in_valid && in_ready;
  // Count after this cycle's load; a load coincident with start is included.
  assign count_d = count_q + {{(c_CNT_W-1){1'b0}}, w_load};
  // count_d is in 2..M when used, so modulo-M arithmetic yields count_d-1.
  assign w_lim_init = count_d[c_ADDR_W-1:0] - c_ADDR_W'(1);

  assign w_j1       = j_q + c_ADDR_W'(1);
  assign w_a        = mem_q[w_j1];
  assign w_b        = mem_q[j_q];
  assign w_end_pass = (j_q == (lim_q - c_ADDR_W'(1)));
  assign w_pass_any = pass_swap_q | w_lt;

  // The only magnitude comparator: is mem[j+1] strictly below mem[j]?
  slt #(.N(N)) u_slt (
    .a_i   (w_a),
    .b_i   (w_b),
    .out_o (w_lt)
  );

  assign in_ready = (state_q == S_LOAD) && (count_q < c_CNT_W'(M));
  assign busy     = (state_q == S_SORT);
  assign done     = done_q;
  assign count    = count_q;
  assign swaps    = swaps_q;
  assign rd_data  = mem_q[rd_addr];

  // Load / sort / done sequencer including the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      count_q     <= '0;
      swaps_q     <= '0;
      j_q         <= '0;
      lim_q       <= '0;
      pass_swap_q <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < M; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          if (w_load) begin
            mem_q[count_q[c_ADDR_W-1:0]] <= in_data;
          end
          count_q <= count_d;
          if (start) begin
            swaps_q <= '0;
            if (count_d <= c_CNT_W'(1)) begin
              // Nothing to compare: finish immediately.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              lim_q       <= w_lim_init;
              j_q         <= '0;
              pass_swap_q <= 1'b0;
              state_q     <= S_SORT;
            end
          end
        end

        S_SORT: begin
          if (w_lt) begin
            mem_q[j_q]  <= w_a;
            mem_q[w_j1] <= w_b;
            if (swaps_q != '1) begin
              swaps_q <= swaps_q + SWAP_W'(1);
            end
          end
          if (w_end_pass) begin
            if (!w_pass_any || (lim_q == c_ADDR_W'(1))) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              lim_q       <= lim_q - c_ADDR_W'(1);
              j_q         <= '0;
              pass_swap_q <= 1'b0;
            end
          end else begin
            j_q         <= w_j1;
            pass_swap_q <= w_pass_any;
          end
        end

        S_DONE: begin
          // Results held; start is ignored here.
          if (clear) begin
            state_q <= S_LOAD;
            count_q <= '0;
          end
        end

        default: begin
          state_q <= S_LOAD;
        end
      endcase
    end
  end

endmodule : slt_sort_engine

`default_nettype wire
